// File: rtl/win3x3_if.sv
// Stream bundle for the 3x3 window generator: pixel input, window output and the line error flag.
// The master side produces pixels and consumes windows; the slave side is the generator.
interface win3x3_if #(
  parameter int DATA_WIDTH = 8
);
  logic                    in_val;
  logic                    in_rdy;
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    in_sof;
  logic                    in_sol;
  logic                    in_eol;
  logic                    in_eof;
  logic                    out3x3_val;
  logic                    out3x3_rdy;
  logic [9*DATA_WIDTH-1:0] out3x3_data;
  logic                    out3x3_sof;
  logic                    out3x3_sol;
  logic                    out3x3_eol;
  logic                    out3x3_eof;
  logic                    line_err;

  modport master (
    output in_val, in_data, in_sof, in_sol, in_eol, in_eof, out3x3_rdy,
    input  in_rdy, out3x3_val, out3x3_data, out3x3_sof, out3x3_sol,
           out3x3_eol, out3x3_eof, line_err
  );

  modport slave (
    input  in_val, in_data, in_sof, in_sol, in_eol, in_eof, out3x3_rdy,
    output in_rdy, out3x3_val, out3x3_data, out3x3_sof, out3x3_sol,
           out3x3_eol, out3x3_eof, line_err
  );
endinterface

// File: rtl/win3x3_gen.sv
// 3x3 window generator: two line buffers plus per-row column taps; emits only full windows,
// so a WxH frame becomes a (W-2)x(H-2) frame with regenerated framing markers.
module win3x3_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LINE   = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic     clk,
  input  logic     rst,
  win3x3_if.slave  bus
);
  // One extra bit so the column counter can sit at MAX_LINE to detect overlong lines.
  localparam int CW = ADDR_WIDTH + 1;

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_reg, state_next;

  logic [CW-1:0]           col_reg, col_next;
  logic [1:0]              row_reg, row_next;
  logic                    line_err_reg, line_err_next;
  logic                    first_reg, first_next;

  logic                    in_rdy, acc, start, take, overflow, proc, emit;
  logic [CW-1:0]           cur_col;
  logic [1:0]              cur_row;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   lb0 [0:MAX_LINE-1];
  logic [DATA_WIDTH-1:0]   lb1 [0:MAX_LINE-1];
  logic [2:0][DATA_WIDTH-1:0] col_in;
  logic [9*DATA_WIDTH-1:0] win_next;

  logic                    out_val_reg, out_sof_reg, out_sol_reg, out_eol_reg, out_eof_reg;
  logic [9*DATA_WIDTH-1:0] out_data_reg;
  logic                    unused_sol;

  assign unused_sol = bus.in_sol;

  assign in_rdy   = (state_reg == IDLE) | ~out_val_reg | bus.out3x3_rdy;
  assign acc      = bus.in_val & in_rdy;
  assign start    = acc & bus.in_sof;
  assign take     = acc & (start | (state_reg == ACTIVE));
  assign cur_col  = start ? '0 : col_reg;
  assign cur_row  = start ? 2'd0 : row_reg;
  assign overflow = cur_col >= CW'(MAX_LINE);
  assign proc     = take & ~overflow;
  assign addr     = cur_col[ADDR_WIDTH-1:0];
  assign emit     = proc & (cur_row == 2'd2) & (cur_col >= CW'(2));

  // Row 0 of the window comes from the older line buffer, row 2 is the live pixel.
  assign col_in = {bus.in_data, lb0[addr], lb1[addr]};

  always_ff @(posedge clk) begin
    if (proc) begin
      lb1[addr] <= lb0[addr];
      lb0[addr] <= bus.in_data;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_row
    logic [DATA_WIDTH-1:0] tap0_reg, tap1_reg;
    always_ff @(posedge clk) begin
      if (proc) begin
        tap1_reg <= tap0_reg;
        tap0_reg <= col_in[gi];
      end
    end
    assign win_next[(8-3*gi)*DATA_WIDTH +: DATA_WIDTH] = tap1_reg;
    assign win_next[(7-3*gi)*DATA_WIDTH +: DATA_WIDTH] = tap0_reg;
    assign win_next[(6-3*gi)*DATA_WIDTH +: DATA_WIDTH] = col_in[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      col_reg      <= '0;
      row_reg      <= '0;
      line_err_reg <= 1'b0;
      first_reg    <= 1'b1;
    end else begin
      state_reg    <= state_next;
      col_reg      <= col_next;
      row_reg      <= row_next;
      line_err_reg <= line_err_next;
      first_reg    <= first_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    col_next      = col_reg;
    row_next      = row_reg;
    line_err_next = line_err_reg;
    first_next    = first_reg;
    if (take) begin
      state_next = ACTIVE;
      if (start) begin
        line_err_next = 1'b0;
        first_next    = 1'b1;
      end
      if (emit)
        first_next = 1'b0;
      // An overlong line parks the column at MAX_LINE until its eol closes it.
      if (overflow && !bus.in_eol) begin
        col_next      = cur_col;
        line_err_next = 1'b1;
      end else if (bus.in_eol) begin
        col_next = '0;
        row_next = (cur_row == 2'd2) ? 2'd2 : cur_row + 2'd1;
      end else begin
        col_next = cur_col + CW'(1);
        row_next = cur_row;
      end
      if (bus.in_eof) begin
        state_next = IDLE;
        col_next   = '0;
        row_next   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_val_reg  <= 1'b0;
      out_data_reg <= '0;
      out_sof_reg  <= 1'b0;
      out_sol_reg  <= 1'b0;
      out_eol_reg  <= 1'b0;
      out_eof_reg  <= 1'b0;
    end else if (emit) begin
      out_val_reg  <= 1'b1;
      out_data_reg <= win_next;
      out_sof_reg  <= first_reg;
      out_sol_reg  <= (cur_col == CW'(2));
      out_eol_reg  <= bus.in_eol;
      out_eof_reg  <= bus.in_eof;
    end else if (out_val_reg && bus.out3x3_rdy) begin
      out_val_reg  <= 1'b0;
    end
  end

  assign bus.in_rdy      = in_rdy;
  assign bus.out3x3_val  = out_val_reg;
  assign bus.out3x3_data = out_data_reg;
  assign bus.out3x3_sof  = out_sof_reg;
  assign bus.out3x3_sol  = out_sol_reg;
  assign bus.out3x3_eol  = out_eol_reg;
  assign bus.out3x3_eof  = out_eof_reg;
  assign bus.line_err    = line_err_reg;
endmodule
